// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
// Optional read bypass is controlled by REGFILE_WB_BYPASS_EN (see top).
`timescale 1ns/1ps
package regfile_wb_pkg;
    localparam int WB_DATA_WIDTH    = 32;
    localparam int WB_REG_FILE_SIZE = 32;
    localparam int WB_LQ_DEPTH      = 4;
    localparam int WB_STARVE_MAX    = 3;
    localparam int WB_AW            = $clog2(WB_REG_FILE_SIZE);
    localparam int WB_CNT_W         = $clog2(WB_LQ_DEPTH) + 1;

    typedef struct packed {
        logic [WB_AW-1:0]         rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LQ
    } wb_src_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ALU result and load-return handshakes feeding the writeback arbiter.
// master = execute/memory side, slave = arbiter.
`timescale 1ns/1ps
interface regfile_wb_arbiter_if
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int AW         = WB_AW
);
    logic                  i_alu_valid;
    logic                  o_alu_ready;
    logic [AW-1:0]         i_alu_rd;
    logic [DATA_WIDTH-1:0] i_alu_data;
    logic                  i_ld_valid;
    logic                  o_ld_ready;
    logic [AW-1:0]         i_ld_rd;
    logic [DATA_WIDTH-1:0] i_ld_data;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_ld_valid, i_ld_rd, i_ld_data,
        input  o_alu_ready, o_ld_ready
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_ld_valid, i_ld_rd, i_ld_data,
        output o_alu_ready, o_ld_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_lq_fifo.sv
// Load-return queue: wrapping-pointer FIFO, head only shows stored entries
// (no fall-through), so a push is visible at the head one cycle later.
`timescale 1ns/1ps
module wb_lq_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int AW         = WB_AW,
    parameter int LQ_DEPTH   = WB_LQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [AW-1:0]                push_rd,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [AW-1:0]                head_rd,
    output logic [DATA_WIDTH-1:0]        head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(LQ_DEPTH):0]    count
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]         rd_mem   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [LQ_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count_q == CW'(LQ_DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = rd_mem[rptr];
    assign head_data = data_mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wptr]   <= push_rd;
            data_mem[wptr] <= push_data;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU results and queued load returns onto the register-file write port.
// Define REGFILE_WB_BYPASS_EN to forward the in-flight write onto the read ports.
`timescale 1ns/1ps
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int REG_FILE_SIZE = WB_REG_FILE_SIZE,
    parameter int LQ_DEPTH      = WB_LQ_DEPTH,
    parameter int STARVE_MAX    = WB_STARVE_MAX
) (
    input  logic                               clk,
    input  logic                               rst,
    regfile_wb_arbiter_if.slave                wb,
    output logic [$clog2(REG_FILE_SIZE)-1:0]   o_waddr,
    output logic [DATA_WIDTH-1:0]              o_wdata,
    output logic                               o_wen,
    output logic [$clog2(LQ_DEPTH):0]          o_lq_count,
    input  logic [$clog2(REG_FILE_SIZE)-1:0]   i_raddr1,
    input  logic [$clog2(REG_FILE_SIZE)-1:0]   i_raddr2,
    input  logic [DATA_WIDTH-1:0]              i_rdata1,
    input  logic [DATA_WIDTH-1:0]              i_rdata2,
    output logic [DATA_WIDTH-1:0]              o_rdata1,
    output logic [DATA_WIDTH-1:0]              o_rdata2
);
    localparam int AW = $clog2(REG_FILE_SIZE);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                  run;
    logic [SW-1:0]         starve_cnt;
    logic                  lq_full;
    logic                  lq_empty;
    logic [AW-1:0]         lq_head_rd;
    logic [DATA_WIDTH-1:0] lq_head_data;
    logic                  lq_push;
    logic                  lq_pop;

    wb_src_e               gnt_src_p0;
    logic [AW-1:0]         req_rd_p0;
    logic [DATA_WIDTH-1:0] req_data_p0;
    logic                  wr_en_p0;

    assign lq_push       = wb.i_ld_valid && wb.o_ld_ready;
    assign lq_pop        = (gnt_src_p0 == WB_LQ);
    assign wb.o_ld_ready = !rst && !lq_full;
    assign wb.o_alu_ready = (gnt_src_p0 == WB_ALU);

    wb_lq_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW),
        .LQ_DEPTH   (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (lq_push),
        .push_rd   (wb.i_ld_rd),
        .push_data (wb.i_ld_data),
        .pop       (lq_pop),
        .head_rd   (lq_head_rd),
        .head_data (lq_head_data),
        .full      (lq_full),
        .empty     (lq_empty),
        .count     (o_lq_count)
    );

    // Holds off grants for the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run <= 1'b0;
        else     run <= 1'b1;
    end

    // Stage p0: arbitration and request select.
    always_comb begin
        gnt_src_p0 = WB_NONE;
        if (run) begin
            if (lq_empty) begin
                if (wb.i_alu_valid) gnt_src_p0 = WB_ALU;
            end else if (wb.i_alu_valid && (starve_cnt == SW'(STARVE_MAX))) begin
                gnt_src_p0 = WB_ALU;
            end else begin
                gnt_src_p0 = WB_LQ;
            end
        end
    end

    always_comb begin
        req_rd_p0   = '0;
        req_data_p0 = '0;
        case (gnt_src_p0)
            WB_ALU: begin
                req_rd_p0   = wb.i_alu_rd;
                req_data_p0 = wb.i_alu_data;
            end
            WB_LQ: begin
                req_rd_p0   = lq_head_rd;
                req_data_p0 = lq_head_data;
            end
            default: begin
                req_rd_p0   = '0;
                req_data_p0 = '0;
            end
        endcase
    end

    // r0 requests are consumed but never written.
    assign wr_en_p0 = (gnt_src_p0 != WB_NONE) && (req_rd_p0 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!wb.i_alu_valid || (gnt_src_p0 == WB_ALU)) begin
            starve_cnt <= '0;
        end else if (gnt_src_p0 == WB_LQ) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Stage p1: registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wen   <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else begin
            o_wen <= wr_en_p0;
            if (wr_en_p0) begin
                o_waddr <= req_rd_p0;
                o_wdata <= req_data_p0;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    always_comb begin
        o_rdata1 = i_rdata1;
        o_rdata2 = i_rdata2;
        if (o_wen && (o_waddr == i_raddr1) && (i_raddr1 != '0)) o_rdata1 = o_wdata;
        if (o_wen && (o_waddr == i_raddr2) && (i_raddr2 != '0)) o_rdata2 = o_wdata;
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^{i_raddr1, i_raddr2};
    assign o_rdata1     = i_rdata1;
    assign o_rdata2     = i_rdata2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: ALU vector table, load queue
// fill/drain with starvation pattern, reset flush, load latency and r0 cases.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic        o_wen;
    logic [2:0]  o_lq_count;
    logic [4:0]  i_raddr1, i_raddr2;
    logic [31:0] i_rdata1, i_rdata2;
    logic [31:0] o_rdata1, o_rdata2;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_WIDTH(32), .AW(5)) wb ();

    regfile_wb_arbiter #(
        .DATA_WIDTH(32), .REG_FILE_SIZE(32), .LQ_DEPTH(4), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen), .o_lq_count(o_lq_count),
        .i_raddr1(i_raddr1), .i_raddr2(i_raddr2), .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
        .o_rdata1(o_rdata1), .o_rdata2(o_rdata2)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } alu_vec_t;

    int checks = 0;
    int failures = 0;
    int alu_seq = 0;
    int ld_seq = 0;

    // Expected writes as {rd, data}; loads use rd 8..15, ALU never does.
    logic [36:0] alu_exp[$];
    logic [36:0] ld_exp[$];

    logic       s_alu_ready, s_ld_ready, s_alu_acc, s_ld_acc;
    logic [2:0] s_lq_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [36:0] w;
        logic [36:0] e;
        s_alu_ready = wb.o_alu_ready;
        s_ld_ready  = wb.o_ld_ready;
        s_lq_count  = o_lq_count;
        s_alu_acc   = wb.i_alu_valid && wb.o_alu_ready;
        s_ld_acc    = wb.i_ld_valid && wb.o_ld_ready;
        if (rst) begin
            alu_exp.delete();
            ld_exp.delete();
        end else begin
            if (o_wen) begin
                w = {o_waddr, o_wdata};
                if (o_waddr >= 5'd8 && o_waddr <= 5'd15) begin
                    if (ld_exp.size() == 0) begin
                        chk("sb_unexpected_ld_write", w, 37'h0);
                    end else begin
                        e = ld_exp.pop_front();
                        chk("sb_ld_write", w, e);
                    end
                end else begin
                    if (alu_exp.size() == 0) begin
                        chk("sb_unexpected_alu_write", w, 37'h0);
                    end else begin
                        e = alu_exp.pop_front();
                        chk("sb_alu_write", w, e);
                    end
                end
            end
            if (s_alu_acc && wb.i_alu_rd != 5'd0) alu_exp.push_back({wb.i_alu_rd, wb.i_alu_data});
            if (s_ld_acc && wb.i_ld_rd != 5'd0)   ld_exp.push_back({wb.i_ld_rd, wb.i_ld_data});
        end
    endtask

    // Called at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu_next();
        wb.i_alu_rd   = 5'(16 + (alu_seq % 8));
        wb.i_alu_data = 32'hC000_0000 + 32'(alu_seq);
    endtask

    task automatic set_ld_next();
        wb.i_ld_rd   = 5'(8 + (ld_seq % 8));
        wb.i_ld_data = 32'hB000_0000 + 32'(ld_seq);
    endtask

    // ALU held valid while loads stream in; every ALU grant with a non-empty
    // queue must follow exactly three queue grants.
    task automatic starve_run(input int ncyc, input int stop_cnt);
        int lq_run = 0;
        int alu_n = 0;
        bit saw_full = 1'b0;
        wb.i_alu_valid = 1'b1;
        set_alu_next();
        wb.i_ld_valid = 1'b1;
        set_ld_next();
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (s_alu_acc) begin
                if (s_lq_count != 3'd0) begin
                    chk("starve_lq_grants_before_alu", 64'(lq_run), 64'd3);
                    alu_n++;
                end
                lq_run = 0;
                alu_seq++;
                set_alu_next();
            end else if (s_lq_count != 3'd0) begin
                lq_run++;
            end
            if (s_lq_count == 3'd4) begin
                saw_full = 1'b1;
                chk("ld_ready_when_full", 64'(s_ld_ready), 64'd0);
            end
            if (s_ld_acc) begin
                ld_seq++;
                set_ld_next();
            end
            if (stop_cnt != 0 && int'(o_lq_count) >= stop_cnt) break;
        end
        if (stop_cnt == 0) begin
            chk("lq_reached_full", 64'(saw_full), 64'd1);
            chk("alu_grants_under_load", 64'(alu_n >= 4), 64'd1);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        alu_vec_t vecs[6];
        int prev;
        vecs[0] = '{5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[2] = '{5'd30, 32'hA5A5A5A5, 1'b1, 5'd30, 32'hA5A5A5A5};
        vecs[3] = '{5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
        vecs[4] = '{5'd0,  32'hCAFE0000, 1'b0, 5'd1,  32'h00000000};
        vecs[5] = '{5'd7,  32'h12345678, 1'b1, 5'd7,  32'h12345678};

        rst = 1'b1;
        wb.i_alu_valid = 1'b1; wb.i_alu_rd = 5'd4; wb.i_alu_data = 32'h4444;
        wb.i_ld_valid = 1'b1;  wb.i_ld_rd = 5'd8;  wb.i_ld_data = 32'h8888;
        i_raddr1 = '0; i_raddr2 = '0; i_rdata1 = '0; i_rdata2 = '0;
        @(posedge clk); #1;
        chk("rst_wen", 64'(o_wen), 64'd0);
        chk("rst_waddr", 64'(o_waddr), 64'd0);
        chk("rst_wdata", 64'(o_wdata), 64'd0);
        chk("rst_lq_count", 64'(o_lq_count), 64'd0);
        chk("rst_alu_ready", 64'(wb.o_alu_ready), 64'd0);
        chk("rst_ld_ready", 64'(wb.o_ld_ready), 64'd0);
        tick();
        wb.i_alu_valid = 1'b0; wb.i_ld_valid = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            wb.i_alu_valid = 1'b1;
            wb.i_alu_rd    = vecs[i].rd;
            wb.i_alu_data  = vecs[i].data;
            tick();
            chk("alu_ready", 64'(s_alu_ready), 64'd1);
            wb.i_alu_valid = 1'b0;
            chk("alu_wen", 64'(o_wen), 64'(vecs[i].exp_wen));
            chk("alu_waddr", 64'(o_waddr), 64'(vecs[i].exp_waddr));
            chk("alu_wdata", 64'(o_wdata), 64'(vecs[i].exp_wdata));
        end

        // rd 7 write is on the port right now.
        i_raddr1 = 5'd7; i_rdata1 = 32'h0;
        i_raddr2 = 5'd7; i_rdata2 = 32'h11;
        #1;
        chk("rdata1_match", 64'(o_rdata1), BYP ? 64'h12345678 : 64'h0);
        chk("rdata2_match", 64'(o_rdata2), BYP ? 64'h12345678 : 64'h11);
        i_raddr1 = 5'd0; i_rdata1 = 32'h0BADF00D;
        #1;
        chk("rdata1_r0_passthru", 64'(o_rdata1), 64'h0BADF00D);
        i_raddr2 = 5'd3;
        #1;
        chk("rdata2_miss_passthru", 64'(o_rdata2), 64'h11);
        tick();

        starve_run(24, 0);
        wb.i_alu_valid = 1'b0;
        wb.i_ld_valid  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_lq_count == 3'd0) break;
            prev = int'(o_lq_count);
            tick();
            chk("drain_count", 64'(o_lq_count), 64'(prev - 1));
            chk("drain_wen", 64'(o_wen), 64'd1);
        end
        chk("drain_empty", 64'(o_lq_count), 64'd0);
        tick();
        tick();
        chk("sb_empty_after_drain", 64'(alu_exp.size() + ld_exp.size()), 64'd0);

        starve_run(30, 3);
        chk("pre_rst_lq_count", 64'(o_lq_count >= 3'd3), 64'd1);
        rst = 1'b1;
        wb.i_alu_valid = 1'b0;
        wb.i_ld_valid  = 1'b0;
        #1;
        chk("midrst_wen", 64'(o_wen), 64'd0);
        chk("midrst_waddr", 64'(o_waddr), 64'd0);
        chk("midrst_wdata", 64'(o_wdata), 64'd0);
        chk("midrst_lq_count", 64'(o_lq_count), 64'd0);
        chk("midrst_ld_ready", 64'(wb.o_ld_ready), 64'd0);
        tick();
        tick();
        wb.i_alu_valid = 1'b1; wb.i_alu_rd = 5'd3; wb.i_alu_data = 32'h3333_0003;
        rst = 1'b0;
        tick();
        chk("post_rst_alu_ready_first", 64'(s_alu_ready), 64'd0);
        chk("post_rst_wen_first_edge", 64'(o_wen), 64'd0);
        tick();
        chk("post_rst_alu_ready", 64'(s_alu_ready), 64'd1);
        wb.i_alu_valid = 1'b0;
        chk("post_rst_wen", 64'(o_wen), 64'd1);
        chk("post_rst_waddr", 64'(o_waddr), 64'd3);

        wb.i_ld_valid = 1'b1; wb.i_ld_rd = 5'd9; wb.i_ld_data = 32'h5555AAAA;
        tick();
        chk("ld_ready_idle", 64'(s_ld_ready), 64'd1);
        wb.i_ld_valid = 1'b0;
        chk("ld_lat_n1_wen", 64'(o_wen), 64'd0);
        chk("ld_lat_n1_count", 64'(o_lq_count), 64'd1);
        tick();
        chk("ld_lat_n2_wen", 64'(o_wen), 64'd1);
        chk("ld_lat_n2_waddr", 64'(o_waddr), 64'd9);
        chk("ld_lat_n2_wdata", 64'(o_wdata), 64'h5555AAAA);

        wb.i_ld_valid = 1'b1; wb.i_ld_rd = 5'd0; wb.i_ld_data = 32'h00000BAD;
        tick();
        wb.i_ld_valid = 1'b0;
        chk("ld_r0_count", 64'(o_lq_count), 64'd1);
        tick();
        chk("ld_r0_popped", 64'(o_lq_count), 64'd0);
        tick();
        chk("ld_r0_wen", 64'(o_wen), 64'd0);
        tick();
        chk("sb_empty_final", 64'(alu_exp.size() + ld_exp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Drives the single write port of the 2-read/1-write register file. Merges two writeback sources onto that port:
- the single-cycle ALU result stream;
- the variable-latency load-return stream, buffered in a small load queue because the memory side cannot stall long.

The block sits between execute/memory and the register file. An optional read-bypass stage hides the register file's write-then-read latency.

Parameters:
DATA_WIDTH, 32, register data width
REG_FILE_SIZE, 32, number of architectural registers; address width = $clog2(REG_FILE_SIZE)
LQ_DEPTH, 4, load queue entries; power of 2, >= 2
STARVE_MAX, 3, max consecutive load-queue grants while ALU is waiting before ALU is forced a grant; >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
i_alu_valid  in  1  ALU result valid
o_alu_ready  out  1  ALU result accepted this cycle
i_alu_rd  in  AW  ALU destination register
i_alu_data  in  DATA_WIDTH  ALU result
i_ld_valid  in  1  load return valid
o_ld_ready  out  1  load queue can accept
i_ld_rd  in  AW  load destination register
i_ld_data  in  DATA_WIDTH  load data
o_waddr  out  AW  register-file write address
o_wdata  out  DATA_WIDTH  register-file write data
o_wen  out  1  register-file write enable
o_lq_count  out  $clog2(LQ_DEPTH)+1  load queue occupancy
i_raddr1, i_raddr2  in  AW  register-file read addresses (snooped)
i_rdata1, i_rdata2  in  DATA_WIDTH  raw register-file read data
o_rdata1, o_rdata2  out  DATA_WIDTH  read data to consumers

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - o_waddr = 0, o_wdata = 0, o_wen = 0.
  - Load queue empty, o_lq_count = 0, starvation counter = 0.
  - While rst = 1, o_alu_ready = 0 and o_ld_ready = 0.
- Reset mid-operation: all queued loads are discarded. No write issues on the edge following reset release.
- Load queue:
  - FIFO with wrapping read/write pointers.
  - o_ld_ready = !full (combinational from registered state).
  - Push on i_ld_valid && o_ld_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - No fall-through: an entry pushed in cycle N is eligible for grant in cycle N+1 at the earliest.
- Arbitration, evaluated each cycle (combinational from state and inputs):
  - LQ empty → grant ALU if i_alu_valid.
  - LQ non-empty and !i_alu_valid → grant LQ head.
  - LQ non-empty and i_alu_valid → grant LQ head, unless starve_cnt == STARVE_MAX, in which case grant ALU.
- Handshakes:
  - o_alu_ready = 1 only in a cycle where the ALU is granted.
  - The ALU side must hold valid/rd/data stable until accepted.
- Starvation counter:
  - Increments on an LQ grant while i_alu_valid.
  - Clears on any ALU grant, and in any cycle where !i_alu_valid.
- Write port:
  - Registered. A grant in cycle N gives o_wen/o_waddr/o_wdata valid in cycle N+1.
  - ALU latency: handshake → write is 1 cycle. Load latency: accept → write is 2 cycles minimum.
  - No grant → o_wen = 0 next cycle. o_waddr/o_wdata hold their previous values.
- Register 0: a granted request with rd == 0 is consumed (pop/ready asserted) but o_wen = 0.
- Ordering: loads leave in arrival order. No ordering is enforced between the ALU and load streams; the scheduler guarantees no same-rd WAW between them.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: o_rdataK = o_wdata when o_wen && o_waddr == i_raddrK && i_raddrK != 0; otherwise o_rdataK = i_rdataK. Purely combinational.
- Undefined: o_rdataK = i_rdataK. The i_raddr ports are unused.

Decomposition:
- Package regfile_wb_pkg:
  - wb_req_t struct {rd, data}.
  - wb_src_e enum {WB_NONE, WB_ALU, WB_LQ}.
  - Localparams for address width and count width.
- Sub-module wb_lq_fifo:
  - Parameterised on DATA_WIDTH, AW, LQ_DEPTH.
  - Ports: push/pop, head, full, empty, count.

Test Plan:
- Reset: rst = 1 mid-stream with 3 loads queued → all outputs 0, o_lq_count = 0; after release, no o_wen on the first edge.
- ALU only: rd = 5, data = 0xDEADBEEF, accepted cycle N → o_wen = 1, o_waddr = 5, o_wdata = 0xDEADBEEF in cycle N+1.
- Fill LQ with 4 loads while ALU is idle:
  - o_ld_ready = 0 at count 4.
  - Drains in order, one per cycle; first write 2 cycles after first accept.
- ALU held valid while LQ refills continuously: with STARVE_MAX = 3, ALU is granted after exactly 3 LQ grants and the pattern repeats.
- rd = 0: ALU rd = 0 → o_alu_ready = 1, o_wen stays 0. Same for a load popped with rd = 0.
- With REGFILE_WB_BYPASS_EN: write rd = 7 = 0x12345678 while i_raddr1 = 7 and i_rdata1 = 0 → o_rdata1 = 0x12345678. Same setup with i_raddr1 = 0 → o_rdata1 = i_rdata1.
